pipe_add_sub: RTL

//  Parametrised, pipelined add/subtract unit for the MIPS datapath (ALU add/sub, address gen).

---
 rtl/pipe_add_sub_pkg.sv | 14 +
 rtl/pipe_add_sub_if.sv | 38 +++
 rtl/pipe_add_sub_stage.sv | 73 +++++++
 rtl/pipe_add_sub.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pipe_add_sub_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
//   OP_ADD / OP_SUB : encoding of the in_sub operation select bit
//   chunk_width()   : per-stage adder width for a given operand width and depth
package pipe_add_sub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Width of the slice handled by one pipeline stage.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipe_add_sub_if.sv
// Handshake bus of the pipelined add/subtract unit.
//   master : operand producer / result consumer (drives in_*, out_ready)
//   slave  : the arithmetic unit (drives in_ready, out_*)
// Signals:
//   in_valid/in_ready    operand handshake
//   in_a, in_b, in_sub   operands and op select (0: A+B, 1: A-B)
//   in_tag               opaque tag returned with the result
//   out_valid/out_ready  result handshake
//   out_sum              result mod 2^WIDTH
//   out_cout, out_ovf    carry out of MSB, two's-complement overflow
//   out_tag              tag of the presented result
interface pipe_add_sub_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );
endinterface

// File: rtl/pipe_add_sub_stage.sv
// One pipeline stage: CHUNK-bit adder with registered sum, carry, overflow
// and the op's valid/sub/tag side-band. All registers advance on i_en.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_en              global advance enable
//   i_valid/i_sub/i_tag  side-band of the op entering this stage
//   i_a, i_b, i_cin   chunk operands (B already conditioned) and carry in
//   o_valid/o_sub/o_tag  registered side-band
//   o_sum, o_cout     registered chunk sum and carry out
//   o_ovf             registered (carry into chunk MSB) ^ (carry out)
module pipe_add_sub_stage #(
  parameter int CHUNK = 8,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic             i_sub,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic             o_valid,
  output logic             o_sub,
  output logic [TAG_W-1:0] o_tag,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  logic [CHUNK:0]   w_full;
  logic             w_c_msb;
  logic             r_valid;
  logic             r_sub;
  logic [TAG_W-1:0] r_tag;
  logic [CHUNK-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  // Chunk adder; the carry into the MSB is recovered from the MSB sum bit.
  always_comb begin
    w_full  = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
    w_c_msb = i_a[CHUNK-1] ^ i_b[CHUNK-1] ^ w_full[CHUNK-1];
  end

  // Stage register: holds everything while the pipe is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_sub   <= 1'b0;
      r_tag   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_sub   <= i_sub;
      r_tag   <= i_tag;
      r_sum   <= w_full[CHUNK-1:0];
      r_cout  <= w_full[CHUNK];
      r_ovf   <= w_c_msb ^ w_full[CHUNK];
    end
  end

  assign o_valid = r_valid;
  assign o_sub   = r_sub;
  assign o_tag   = r_tag;
  assign o_sum   = r_sum;
  assign o_cout  = r_cout;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined add/subtract unit: WIDTH-bit operands split into STAGES chunks,
// one chunk added per stage with the carry registered between stages.
// Chunk k of the operands is skewed k stages before its adder and its sum
// is deskewed STAGES-1-k stages afterwards so all chunks leave together.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   bus         pipe_add_sub_if.slave (operand/result handshake, flags, tag)
module pipe_add_sub
  import pipe_add_sub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input logic           clk,
  input logic           rst_n,
  pipe_add_sub_if.slave bus
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if ((WIDTH % STAGES) != 0) begin : g_width_check
    $error("pipe_add_sub: WIDTH must be a multiple of STAGES");
  end

  logic              w_adv;
  logic [WIDTH-1:0]  w_b_eff;
  logic [STAGES-1:0] w_valid;
  logic [STAGES-1:0] w_sub;
  logic [STAGES-1:0] w_cout;
  logic [STAGES-1:0] w_ovf;
  logic [TAG_W-1:0]  w_tag [STAGES];
  logic [CHUNK-1:0]  w_sum [STAGES];
  logic [WIDTH-1:0]  w_sum_out;
  logic              w_unused;

  // Single enable for every register: the pipe moves unless a result is blocked.
  assign w_adv        = !w_valid[STAGES-1] || bus.out_ready;
  assign bus.in_ready = w_adv;

  // Subtraction is A + ~B + 1; the +1 enters as chunk 0's carry-in.
  always_comb begin
    if (bus.in_sub == OP_SUB) begin
      w_b_eff = ~bus.in_b;
    end else begin
      w_b_eff = bus.in_b;
    end
  end

  for (genvar gk = 0; gk < STAGES; gk++) begin : g_chunk
    logic [CHUNK-1:0] w_a_k;
    logic [CHUNK-1:0] w_b_k;
    logic             w_cin_k;
    logic             w_vin_k;
    logic             w_sin_k;
    logic [TAG_W-1:0] w_tin_k;

    if (gk == 0) begin : g_head
      assign w_a_k   = bus.in_a[CHUNK-1:0];
      assign w_b_k   = w_b_eff[CHUNK-1:0];
      assign w_cin_k = bus.in_sub;
      assign w_vin_k = bus.in_valid;
      assign w_sin_k = bus.in_sub;
      assign w_tin_k = bus.in_tag;
    end else begin : g_skew
      logic [CHUNK-1:0] r_a_dly [gk];
      logic [CHUNK-1:0] r_b_dly [gk];

      // Input skew: chunk gk waits gk stages until its carry arrives.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < gk; j++) begin
            r_a_dly[j] <= '0;
            r_b_dly[j] <= '0;
          end
        end else if (w_adv) begin
          r_a_dly[0] <= bus.in_a[gk*CHUNK +: CHUNK];
          r_b_dly[0] <= w_b_eff[gk*CHUNK +: CHUNK];
          for (int j = 1; j < gk; j++) begin
            r_a_dly[j] <= r_a_dly[j-1];
            r_b_dly[j] <= r_b_dly[j-1];
          end
        end
      end

      assign w_a_k   = r_a_dly[gk-1];
      assign w_b_k   = r_b_dly[gk-1];
      assign w_cin_k = w_cout[gk-1];
      assign w_vin_k = w_valid[gk-1];
      assign w_sin_k = w_sub[gk-1];
      assign w_tin_k = w_tag[gk-1];
    end

    pipe_add_sub_stage #(
      .CHUNK (CHUNK),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_adv),
      .i_valid (w_vin_k),
      .i_sub   (w_sin_k),
      .i_tag   (w_tin_k),
      .i_a     (w_a_k),
      .i_b     (w_b_k),
      .i_cin   (w_cin_k),
      .o_valid (w_valid[gk]),
      .o_sub   (w_sub[gk]),
      .o_tag   (w_tag[gk]),
      .o_sum   (w_sum[gk]),
      .o_cout  (w_cout[gk]),
      .o_ovf   (w_ovf[gk])
    );

    if (gk == STAGES - 1) begin : g_top_chunk
      assign w_sum_out[gk*CHUNK +: CHUNK] = w_sum[gk];
    end else begin : g_deskew
      localparam int DLY = STAGES - 1 - gk;
      logic [CHUNK-1:0] r_dly [DLY];

      // Output deskew: hold this chunk's sum until the final chunk catches up.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < DLY; j++) begin
            r_dly[j] <= '0;
          end
        end else if (w_adv) begin
          r_dly[0] <= w_sum[gk];
          for (int j = 1; j < DLY; j++) begin
            r_dly[j] <= r_dly[j-1];
          end
        end
      end

      assign w_sum_out[gk*CHUNK +: CHUNK] = r_dly[DLY-1];
    end
  end

  // The sub bit only rides along for ordering; overflow of inner chunks is not a result.
  assign w_unused = ^{w_sub, w_ovf};

  assign bus.out_valid = w_valid[STAGES-1];
  assign bus.out_sum   = w_sum_out;
  assign bus.out_cout  = w_cout[STAGES-1];
  assign bus.out_ovf   = w_ovf[STAGES-1];
  assign bus.out_tag   = w_tag[STAGES-1];

endmodule
